logic_gate_pipe: RTL and testbench

Parametrised, registered successor to the team's 2-input OR gate family: a NUM_IN-input, WIDTH-bit bitwise logic unit with a runtime-selectable operation (AND/OR/XOR/NAND/NOR/XNOR/pass/zero). It sits on a valid/ready stream between a producer and a consumer, registers its result with one cycle of latency and applies backpressure. It also counts completed operations for bench and debug visibility.

---
 rtl/logic_gate_pipe.sv | 120 ++++++++++++
 tb/tb_logic_gate_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: NUM_IN-lane, WIDTH-bit bitwise logic unit on a valid/ready
// stream. The result is held in a single output register with pass-through
// backpressure, so the unit sustains one operation per cycle when the consumer
// is always ready. A wrapping counter records how many results were consumed.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [2:0]              out_mode,
    output logic [CNT_W-1:0]        op_count
);

    // Operation codes carried on mode / out_mode.
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_ZERO = 3'd7
    } op_e;

    logic [WIDTH-1:0] and_all;
    logic [WIDTH-1:0] or_all;
    logic [WIDTH-1:0] xor_all;
    logic [WIDTH-1:0] result;

    logic             accept;
    logic             consume;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [2:0]       mode_q,  mode_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Reduce every operand lane bitwise; the inverted ops reuse these three.
    always_comb begin
        and_all = '1;
        or_all  = '0;
        xor_all = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            and_all = and_all & in_data[k*WIDTH +: WIDTH];
            or_all  = or_all  | in_data[k*WIDTH +: WIDTH];
            xor_all = xor_all ^ in_data[k*WIDTH +: WIDTH];
        end
    end

    // Pick the requested operation from the lane reductions.
    always_comb begin
        result = '0;
        case (op_e'(mode))
            OP_AND:  result = and_all;
            OP_OR:   result = or_all;
            OP_XOR:  result = xor_all;
            OP_NAND: result = ~and_all;
            OP_NOR:  result = ~or_all;
            OP_XNOR: result = ~xor_all;
            OP_PASS: result = in_data[WIDTH-1:0];
            OP_ZERO: result = '0;
            default: result = '0;
        endcase
    end

    // The register can take new work whenever it is empty or being drained now.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // Next state: a new accept replaces the held result (even while it is
    // being consumed); a consume without an accept empties the register.
    // Data is only loaded on accept so unaccepted inputs never reach out_data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        count_d = count_q;
        if (consume) begin
            valid_d = 1'b0;
            count_d = count_q + CNT_W'(1);
        end
        if (accept) begin
            valid_d = 1'b1;
            data_d  = result;
            mode_d  = mode;
        end
    end

    // State register; reset wins over any accept or consume in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= 3'd0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Testbench for logic_gate_pipe. Instance A is a 1-bit, 2-lane gate with a
// 4-bit counter (truth tables, counter wrap); instance B is an 8-bit, 4-lane
// unit with a 16-bit counter checked against a per-bit ones-count model.
module tb_logic_gate_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A signals
    logic        rstA;
    logic        aInValid, aInReady, aOutValid, aOutReady;
    logic [1:0]  aInData;
    logic [2:0]  aMode, aOutMode;
    logic [0:0]  aOutData;
    logic [3:0]  aOpCount;

    // Instance B signals
    logic        rstB;
    logic        bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bInData;
    logic [2:0]  bMode, bOutMode;
    logic [7:0]  bOutData;
    logic [15:0] bOpCount;

    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(4)) dutA (
        .clk(clk), .rst(rstA),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .mode(aMode),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .out_mode(aOutMode), .op_count(aOpCount)
    );

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(16)) dutB (
        .clk(clk), .rst(rstB),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .mode(bMode),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .out_mode(bOutMode), .op_count(bOpCount)
    );

    // Reference model for B: results waiting for the consumer, plus consumed count.
    logic [10:0] pend[$];
    logic [15:0] mCount = '0;
    logic        expReadyB;

    // Per output bit, count how many of the four lanes have that bit set.
    function automatic logic [7:0] refOp(input logic [31:0] d, input logic [2:0] m);
        logic [7:0] r;
        int ones;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ones = 0;
            for (int k = 0; k < 4; k++) ones += int'(d[k*8+i]);
            case (m)
                3'd0: r[i] = (ones == 4);
                3'd1: r[i] = (ones > 0);
                3'd2: r[i] = (ones % 2 == 1);
                3'd3: r[i] = (ones != 4);
                3'd4: r[i] = (ones == 0);
                3'd5: r[i] = (ones % 2 == 0);
                3'd6: r[i] = d[i];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Drive B's inputs just after a falling edge and predict in_ready.
    task automatic setB(input logic v, input logic [31:0] d, input logic [2:0] m,
                        input logic ordy, input logic r);
        bInValid  = v;
        bInData   = d;
        bMode     = m;
        bOutReady = ordy;
        rstB      = r;
        #1;
        expReadyB = (pend.size() == 0) || ordy;
    endtask

    // Advance one clock, updating the B model at the rising edge.
    task automatic clockB();
        @(posedge clk);
        if (rstB) begin
            pend.delete();
            mCount = '0;
        end else begin
            if (pend.size() != 0 && bOutReady) begin
                void'(pend.pop_front());
                mCount = mCount + 16'd1;
            end
            if (bInValid && expReadyB) pend.push_back({bMode, refOp(bInData, bMode)});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstA = 1'b1; aInValid = 1'b1; aInData = 2'b11; aMode = 3'd1; aOutReady = 1'b0;
        repeat (2) begin
            setB(1'b1, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b1);
            clockB();
        end
        rstA = 1'b0; aInValid = 1'b0;
        setB(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        checks++; if (aOutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_valid got=%0b exp=0", aOutValid); end
        checks++; if (aOutData !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_data got=%0h exp=0", aOutData); end
        checks++; if (aOutMode !== 3'd0) begin errors++; $display("[TB] FAIL reset_a_mode got=%0d exp=0", aOutMode); end
        checks++; if (aOpCount !== 4'd0) begin errors++; $display("[TB] FAIL reset_a_count got=%0d exp=0", aOpCount); end
        checks++; if (aInReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_ready got=%0b exp=1", aInReady); end
        checks++; if (bOutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_valid got=%0b exp=0", bOutValid); end
        checks++; if (bOutData !== 8'h00) begin errors++; $display("[TB] FAIL reset_b_data got=%0h exp=0", bOutData); end
        checks++; if (bOutMode !== 3'd0) begin errors++; $display("[TB] FAIL reset_b_mode got=%0d exp=0", bOutMode); end
        checks++; if (bOpCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_b_count got=%0d exp=0", bOpCount); end
        checks++; if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_ready got=%0b exp=1", bInReady); end
    endtask

    task automatic test_truth_table();
        logic [2:0] modes [3];
        logic [3:0] expTab [3];
        logic [3:0] row;
        modes  = '{3'd1, 3'd0, 3'd2};
        expTab = '{4'b1110, 4'b1000, 4'b0110};
        bInValid = 1'b0; bOutReady = 1'b0;
        aOutReady = 1'b1;
        for (int m = 0; m < 3; m++) begin
            row = expTab[m];
            for (int v = 0; v < 4; v++) begin
                aInValid = 1'b1; aInData = 2'(v); aMode = modes[m];
                @(posedge clk); @(negedge clk);
                checks++; if (aOutValid !== 1'b1 || aOutData[0] !== row[v])
                    begin errors++; $display("[TB] FAIL truth_mode%0d_in%0d got=%0b/%0b exp=1/%0b", modes[m], v, aOutValid, aOutData, row[v]); end
                checks++; if (aOutMode !== modes[m])
                    begin errors++; $display("[TB] FAIL truth_outmode got=%0d exp=%0d", aOutMode, modes[m]); end
            end
        end
        aInValid = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        rstA = 1'b1; aInValid = 1'b0; aOutReady = 1'b1;
        @(posedge clk); @(negedge clk);
        rstA = 1'b0;
        for (int i = 0; i < 18; i++) begin
            aInValid = (i < 17); aInData = 2'($urandom); aMode = 3'($urandom_range(0, 7));
            @(posedge clk); @(negedge clk);
            checks++; if (aOpCount !== 4'(i % 16))
                begin errors++; $display("[TB] FAIL wrap_count_%0d got=%0d exp=%0d", i, aOpCount, i % 16); end
        end
        aInValid = 1'b0; aOutReady = 1'b0;
    endtask

    task automatic test_multilane();
        logic [7:0] expConst [8];
        expConst = '{8'h01, 8'hFF, 8'h96, 8'hFE, 8'h00, 8'h69, 8'h0F, 8'h00};
        for (int m = 0; m < 8; m++) begin
            setB(1'b1, 32'hFF55_330F, 3'(m), 1'b1, 1'b0);
            clockB();
            checks++; if (bOutValid !== 1'b1 || bOutData !== expConst[m])
                begin errors++; $display("[TB] FAIL lanes_mode%0d got=%0b/%0h exp=1/%0h", m, bOutValid, bOutData, expConst[m]); end
            checks++; if (bOutData !== refOp(32'hFF55_330F, 3'(m)))
                begin errors++; $display("[TB] FAIL lanes_model%0d got=%0h exp=%0h", m, bOutData, refOp(32'hFF55_330F, 3'(m))); end
        end
        setB(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        clockB();
    endtask

    task automatic test_backpressure();
        setB(1'b0, 32'h0, 3'd0, 1'b0, 1'b1); clockB();
        setB(1'b1, 32'h0000_00AA, 3'd6, 1'b0, 1'b0);
        checks++; if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_ready got=%0b exp=1", bInReady); end
        clockB();
        for (int c = 0; c < 5; c++) begin
            setB(1'b1, 32'h0000_0055 | ($urandom & 32'hFFFF_FF00), 3'd6, 1'b0, 1'b0);
            checks++; if (bInReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready got=%0b exp=0", bInReady); end
            clockB();
            checks++; if (bOutValid !== 1'b1 || bOutData !== 8'hAA || bOutMode !== 3'd6)
                begin errors++; $display("[TB] FAIL bp_hold got=%0b/%0h/%0d exp=1/aa/6", bOutValid, bOutData, bOutMode); end
            checks++; if (bOpCount !== 16'd0) begin errors++; $display("[TB] FAIL bp_hold_count got=%0d exp=0", bOpCount); end
        end
        setB(1'b1, 32'h0000_0055, 3'd6, 1'b1, 1'b0);
        checks++; if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got=%0b exp=1", bInReady); end
        clockB();
        checks++; if (bOpCount !== 16'd1) begin errors++; $display("[TB] FAIL bp_release_count got=%0d exp=1", bOpCount); end
        checks++; if (bOutValid !== 1'b1 || bOutData !== 8'h55)
            begin errors++; $display("[TB] FAIL bp_release_data got=%0b/%0h exp=1/55", bOutValid, bOutData); end
        setB(1'b0, 32'h0, 3'd0, 1'b1, 1'b0); clockB();
        checks++; if (bOpCount !== 16'd2 || bOutValid !== 1'b0)
            begin errors++; $display("[TB] FAIL bp_drain got=%0d/%0b exp=2/0", bOpCount, bOutValid); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] expQ[$];
        logic [10:0] e;
        logic [31:0] d;
        logic [2:0]  m;
        setB(1'b0, 32'h0, 3'd0, 1'b0, 1'b1); clockB();
        for (int i = 0; i < 100; i++) begin
            d = $urandom; m = 3'($urandom_range(0, 7));
            setB(1'b1, d, m, 1'b1, 1'b0);
            checks++; if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready_%0d got=%0b exp=1", i, bInReady); end
            expQ.push_back({m, refOp(d, m)});
            clockB();
            e = expQ.pop_front();
            checks++; if (bOutValid !== 1'b1 || bOutData !== e[7:0] || bOutMode !== e[10:8])
                begin errors++; $display("[TB] FAIL stream_res_%0d got=%0b/%0h/%0d exp=1/%0h/%0d", i, bOutValid, bOutData, bOutMode, e[7:0], e[10:8]); end
            checks++; if (bOpCount !== 16'(i))
                begin errors++; $display("[TB] FAIL stream_count_%0d got=%0d exp=%0d", i, bOpCount, i); end
        end
        setB(1'b0, 32'h0, 3'd0, 1'b1, 1'b0); clockB();
        checks++; if (bOpCount !== 16'd100 || bOutValid !== 1'b0)
            begin errors++; $display("[TB] FAIL stream_total got=%0d/%0b exp=100/0", bOpCount, bOutValid); end
    endtask

    task automatic test_reset_mid();
        setB(1'b0, 32'h0, 3'd0, 1'b0, 1'b1); clockB();
        setB(1'b1, 32'h1234_56C3, 3'd1, 1'b0, 1'b0); clockB();
        checks++; if (bOutValid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_loaded got=%0b exp=1", bOutValid); end
        setB(1'b1, $urandom, 3'd2, 1'b0, 1'b1); clockB();
        setB(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        checks++; if (bOutValid !== 1'b0 || bOutData !== 8'h00 || bOutMode !== 3'd0)
            begin errors++; $display("[TB] FAIL rstmid_clear got=%0b/%0h/%0d exp=0/0/0", bOutValid, bOutData, bOutMode); end
        checks++; if (bOpCount !== 16'd0) begin errors++; $display("[TB] FAIL rstmid_count got=%0d exp=0", bOpCount); end
        checks++; if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready got=%0b exp=1", bInReady); end
        clockB();
        checks++; if (bOpCount !== 16'd0 || bOutValid !== 1'b0)
            begin errors++; $display("[TB] FAIL rstmid_no_emit got=%0d/%0b exp=0/0", bOpCount, bOutValid); end
        setB(1'b1, 32'hDEAD_BEEF, 3'd1, 1'b0, 1'b0); clockB();
        setB(1'b1, 32'hCAFE_F00D, 3'd0, 1'b1, 1'b1); clockB();
        checks++; if (bOpCount !== 16'd0 || bOutValid !== 1'b0)
            begin errors++; $display("[TB] FAIL rst_over_consume got=%0d/%0b exp=0/0", bOpCount, bOutValid); end
    endtask

    task automatic test_random();
        logic [10:0] e;
        logic        r;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            setB(1'(($urandom % 4) != 0), $urandom, 3'($urandom_range(0, 7)), 1'($urandom % 2), r);
            checks++; if (bInReady !== expReadyB)
                begin errors++; $display("[TB] FAIL rand_ready_%0d got=%0b exp=%0b", i, bInReady, expReadyB); end
            clockB();
            checks++; if (bOutValid !== (pend.size() != 0))
                begin errors++; $display("[TB] FAIL rand_valid_%0d got=%0b exp=%0b", i, bOutValid, pend.size() != 0); end
            if (pend.size() != 0) begin
                e = pend[0];
                checks++; if (bOutData !== e[7:0] || bOutMode !== e[10:8])
                    begin errors++; $display("[TB] FAIL rand_data_%0d got=%0h/%0d exp=%0h/%0d", i, bOutData, bOutMode, e[7:0], e[10:8]); end
            end
            checks++; if (bOpCount !== mCount)
                begin errors++; $display("[TB] FAIL rand_count_%0d got=%0d exp=%0d", i, bOpCount, mCount); end
        end
    endtask

    initial begin
        rstA = 1'b1; aInValid = 1'b0; aInData = '0; aMode = '0; aOutReady = 1'b0;
        rstB = 1'b1; bInValid = 1'b0; bInData = '0; bMode = '0; bOutReady = 1'b0;
        @(negedge clk);
        test_reset();
        test_truth_table();
        test_counter_wrap();
        test_multilane();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
